// File: rtl/burst_mem_responder_if.sv
// Burst bus between cacheline_adaptor (master) and the line-array responder (slave).
// Four 64-bit beats per line, qualified by resp_o.
interface burst_mem_responder_if;
   logic [31:0] address_i;
   logic        read_i;
   logic        write_i;
   logic [63:0] burst_i;
   logic [63:0] burst_o;
   logic        resp_o;
   logic        err_o;

   modport master (
      output address_i, read_i, write_i, burst_i,
      input  burst_o, resp_o, err_o
   );

   modport slave (
      input  address_i, read_i, write_i, burst_i,
      output burst_o, resp_o, err_o
   );
endinterface

// File: rtl/burst_mem_responder.sv
// Memory-side responder: accepts one line read/write, waits LATENCY cycles,
// then streams four 64-bit beats to/from an on-chip line array.
module burst_mem_responder #(
   parameter int unsigned LATENCY  = 4,
   parameter int unsigned IDX_BITS = 6
) (
   input  logic                  clk,
   input  logic                  reset_n,
   burst_mem_responder_if.slave  bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] BURST = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]          state_q;
   logic [4:0]          cnt_q;
   logic [1:0]          beat_q;
   logic [IDX_BITS-1:0] idx_q;
   logic                wr_q;
   logic                resp_q;
   logic                err_q;
   logic [63:0]         rdata_q;
   logic [1:0]          beat_nx;

   // Line array is deliberately left unreset.
   logic [63:0] mem [2**IDX_BITS][4];

   // Offset bits and aliased upper bits are intentionally ignored.
   logic unused_addr;
   assign unused_addr = ^{bus.address_i[31:5+IDX_BITS], bus.address_i[4:0]};

   assign beat_nx = beat_q + 2'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         beat_q  <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         resp_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.read_i ^ bus.write_i) begin
                  idx_q   <= bus.address_i[5 +: IDX_BITS];
                  wr_q    <= bus.write_i;
                  cnt_q   <= 5'(LATENCY - 1);
                  state_q <= WAIT;
               end else if (bus.read_i && bus.write_i) begin
                  err_q <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= BURST;
                  beat_q  <= '0;
                  resp_q  <= 1'b1;
                  rdata_q <= wr_q ? '0 : mem[idx_q][0];
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            BURST: begin
               if (beat_q == 2'd3) begin
                  resp_q  <= 1'b0;
                  rdata_q <= '0;
                  beat_q  <= '0;
                  state_q <= DONE;
               end else begin
                  beat_q  <= beat_nx;
                  rdata_q <= wr_q ? '0 : mem[idx_q][beat_nx];
               end
            end
            default: begin
               // Hold here until the requester releases, so a held request is not re-accepted.
               if (!bus.read_i && !bus.write_i)
                  state_q <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == BURST && wr_q)
         mem[idx_q][beat_q] <= bus.burst_i;
   end

   assign bus.resp_o  = resp_q;
   assign bus.burst_o = rdata_q;
   assign bus.err_o   = err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder: scoreboard of expected read beats
// backed by a bench-side line model.
module tb_burst_mem_responder;

   localparam int unsigned LAT = 4;

   logic clk;
   logic reset_n;

   burst_mem_responder_if bus ();

   burst_mem_responder #(.LATENCY(LAT), .IDX_BITS(6)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   logic [63:0] model [64][4];
   logic [63:0] wbeats [4];
   logic [63:0] sb_q [$];

   // One transaction: request held until `hold` cycles after the burst, or
   // reset asserted right after `abort_at` write beats have been consumed.
   task automatic xfer(input bit wr, input logic [31:0] addr,
                       input int unsigned hold, input int unsigned abort_at);
      int unsigned k, first, nresp, extra;
      logic [5:0]  idx;
      logic [63:0] exp;
      idx = addr[10:5];
      if (!wr)
         for (int unsigned b = 0; b < 4; b++) sb_q.push_back(model[idx][b]);
      @(posedge clk); #1;
      bus.address_i = addr;
      bus.read_i    = !wr;
      bus.write_i   = wr;
      bus.burst_i   = wbeats[0];
      k = 0; first = 0; nresp = 0;
      while (nresp < 4 && k < 100) begin
         @(negedge clk); k++;
         if (bus.resp_o) begin
            if (nresp == 0) first = k;
            if (!wr) begin
               total++;
               if (sb_q.size() == 0) begin
                  $display("FAIL sb_underflow beat=%0d got=%h required=scoreboard entry", nresp, bus.burst_o);
               end else begin
                  exp = sb_q.pop_front();
                  if (bus.burst_o !== exp)
                     $display("FAIL read_beat%0d addr=%h got=%h required=%h", nresp, addr, bus.burst_o, exp);
                  else passed++;
               end
            end
            if (wr) model[idx][nresp] = wbeats[nresp];
            nresp++;
            if (wr) begin
               @(posedge clk); #1;
               if (nresp < 4) bus.burst_i = wbeats[nresp];
               if (nresp == abort_at) begin
                  reset_n = 1'b0;
                  #1;
                  total++;
                  if (bus.resp_o !== 1'b0)
                     $display("FAIL abort_resp_drop got=%b required=0", bus.resp_o);
                  else passed++;
                  bus.write_i = 1'b0;
                  return;
               end
            end
         end
      end
      total++;
      if (nresp != 4)
         $display("FAIL timeout addr=%h beats_seen=%0d required=4", addr, nresp);
      else passed++;
      total++;
      if (first != LAT + 2)
         $display("FAIL latency addr=%h got_cycle=%0d required=%0d", addr, first, LAT + 2);
      else passed++;
      @(negedge clk);
      total++;
      if (bus.resp_o !== 1'b0 || bus.burst_o !== 64'h0)
         $display("FAIL after_burst resp=%b burst=%h required resp=0 burst=0", bus.resp_o, bus.burst_o);
      else passed++;
      extra = 0;
      for (int unsigned c = 0; c < hold; c++) begin
         @(negedge clk);
         if (bus.resp_o !== 1'b0) extra++;
      end
      if (hold > 0) begin
         total++;
         if (extra != 0)
            $display("FAIL held_request extra_resp_cycles=%0d required=0", extra);
         else passed++;
      end
      @(posedge clk); #1;
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset;
      reset_n     = 1'b0;
      bus.read_i  = 1'b1;
      bus.write_i = 1'b0;
      bus.address_i = 32'h0000_0040;
      bus.burst_i = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         total++;
         if (bus.resp_o !== 1'b0 || bus.burst_o !== 64'h0 || bus.err_o !== 1'b0)
            $display("FAIL reset_cycle%0d resp=%b burst=%h err=%b required all 0", c, bus.resp_o, bus.burst_o, bus.err_o);
         else passed++;
      end
      bus.read_i = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_write_read;
      for (int unsigned b = 0; b < 4; b++) wbeats[b] = 64'hA0A0_0000_0000_0000 | 64'(b);
      xfer(1'b1, 32'h0000_0040, 0, 99);
      xfer(1'b0, 32'h0000_0040, 0, 99);
   endtask

   task automatic test_alias;
      xfer(1'b0, 32'h0000_205F, 0, 99);
   endtask

   task automatic test_held_request;
      xfer(1'b0, 32'h0000_0040, 20, 99);
   endtask

   task automatic test_conflict;
      int unsigned rcount;
      @(posedge clk); #1;
      bus.address_i = 32'h0000_0040;
      bus.read_i    = 1'b1;
      bus.write_i   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.err_o !== 1'b1)
         $display("FAIL conflict_err got=%b required=1", bus.err_o);
      else passed++;
      rcount = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.resp_o !== 1'b0) rcount++;
      end
      total++;
      if (rcount != 0)
         $display("FAIL conflict_resp resp_cycles=%0d required=0", rcount);
      else passed++;
      @(posedge clk); #1;
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      xfer(1'b0, 32'h0000_0040, 0, 99);
      total++;
      if (bus.err_o !== 1'b1)
         $display("FAIL err_sticky got=%b required=1", bus.err_o);
      else passed++;
   endtask

   task automatic test_back_to_back;
      for (int unsigned b = 0; b < 4; b++) wbeats[b] = {$urandom, $urandom};
      xfer(1'b1, 32'h0000_07E0, 0, 99);
      for (int unsigned b = 0; b < 4; b++) wbeats[b] = {$urandom, $urandom};
      xfer(1'b1, 32'h0000_0060, 0, 99);
      xfer(1'b0, 32'h0000_07E0, 0, 99);
      xfer(1'b0, 32'h0000_0060, 0, 99);
      xfer(1'b0, 32'h0000_0040, 0, 99);
   endtask

   task automatic test_reset_mid_write;
      for (int unsigned b = 0; b < 4; b++) wbeats[b] = 64'hB0B0_0000_0000_0000 | 64'(b);
      xfer(1'b1, 32'h0000_0080, 0, 99);
      for (int unsigned b = 0; b < 4; b++) wbeats[b] = 64'hC0C0_0000_0000_0000 | 64'(b);
      xfer(1'b1, 32'h0000_0080, 0, 2);
      @(negedge clk);
      total++;
      if (bus.err_o !== 1'b0 || bus.resp_o !== 1'b0)
         $display("FAIL in_reset err=%b resp=%b required err=0 resp=0", bus.err_o, bus.resp_o);
      else passed++;
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      xfer(1'b0, 32'h0000_0080, 0, 99);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_alias();
      test_held_request();
      test_conflict();
      test_back_to_back();
      test_reset_mid_write();
      total++;
      if (sb_q.size() != 0)
         $display("FAIL sb_leftover entries=%0d required=0", sb_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
